e_mdu_ctrl: RTL and testbench

- Execute-stage multiply/divide controller. Sits beside the E-stage ALU and shares its A/B operand buses.
- Accepts MDU ops from the E pipeline register and sequences a fixed-latency multiply or divide with a busy counter.
- Owns the HI/LO architectural registers and serves mfhi/mflo reads.
- Provides the busy/start indication used by the hazard unit to stall D-stage MDU instructions.
- Honours exception/interrupt flush requests.

---
 rtl/e_mdu_ctrl_pkg.sv | 34 +++
 rtl/e_mdu_calc.sv | 53 +++++
 rtl/e_mdu_ctrl.sv | 103 ++++++++++
 tb/tb_e_mdu_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/e_mdu_ctrl_pkg.sv
// Shared MDU definitions: mdu_op encodings, default latencies and op-class helpers.
package e_mdu_ctrl_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MFHI  = 4'd7,
        MDU_MFLO  = 4'd8
    } mdu_op_e;

    // What the in-flight operation will do to HI/LO when its count expires
    typedef enum logic [1:0] {
        PEND_NONE    = 2'd0,
        PEND_RESULT  = 2'd1,
        PEND_DIVZERO = 2'd2
    } pend_kind_e;

    localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
    localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// Combinational 64-bit multiply/divide result generator; result = {hi, lo}.
module e_mdu_calc
    import e_mdu_ctrl_pkg::*;
(
    input  logic [3:0]  mdu_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [63:0] result,
    output logic        div_zero
);

    mdu_op_e            op;
    logic signed [63:0] sprod;
    logic [63:0]        uprod;
    logic signed [31:0] sq;
    logic signed [31:0] sr;

    assign op    = mdu_op_e'(mdu_op);
    assign sprod = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign uprod = {32'b0, A} * {32'b0, B};

    always_comb begin
        result   = '0;
        div_zero = 1'b0;
        sq       = '0;
        sr       = '0;
        case (op)
            MDU_MULT:  result = sprod;
            MDU_MULTU: result = uprod;
            MDU_DIV: begin
                if (B == '0) begin
                    div_zero = 1'b1;
                end else if (A == 32'h8000_0000 && B == '1) begin
                    // most-negative / -1 overflows; the architected result wraps
                    result = {32'h0, 32'h8000_0000};
                end else begin
                    sq     = $signed(A) / $signed(B);
                    sr     = $signed(A) % $signed(B);
                    result = {sr, sq};
                end
            end
            MDU_DIVU: begin
                if (B == '0) begin
                    div_zero = 1'b1;
                end else begin
                    result = {A % B, A / B};
                end
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/e_mdu_ctrl.sv
// E-stage MDU controller: fixed-latency mult/div sequencing, HI/LO ownership, mfhi/mflo reads.
// Optional `MDU_ABORT_EN: req during busy aborts the in-flight op.
module e_mdu_ctrl
    import e_mdu_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        start,
    output logic        busy,
    output logic [31:0] mdu_out,
    output logic [31:0] hi_q,
    output logic [31:0] lo_q
);

    mdu_op_e    op;
    logic [3:0] cnt;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    pend_kind_e pend_kind;
    logic [63:0] calc_res;
    logic        calc_dz;
    logic        abort;

    assign op    = mdu_op_e'(mdu_op);
    assign start = is_muldiv(mdu_op) && !req && !busy;
    assign hi_q  = hi;
    assign lo_q  = lo;

`ifdef MDU_ABORT_EN
    assign abort = busy & req;
`else
    assign abort = 1'b0;
`endif

    e_mdu_calc u_calc (
        .mdu_op   (mdu_op),
        .A        (A),
        .B        (B),
        .result   (calc_res),
        .div_zero (calc_dz)
    );

    always_comb begin
        mdu_out = '0;
        case (op)
            MDU_MFHI: mdu_out = hi;
            MDU_MFLO: mdu_out = lo;
            default:  mdu_out = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy      <= 1'b0;
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            pend_hi   <= '0;
            pend_lo   <= '0;
            pend_kind <= PEND_NONE;
        end else if (abort) begin
            busy      <= 1'b0;
            cnt       <= '0;
            pend_hi   <= '0;
            pend_lo   <= '0;
            pend_kind <= PEND_NONE;
        end else if (busy) begin
            if (cnt == 4'd1) begin
                busy      <= 1'b0;
                cnt       <= '0;
                pend_kind <= PEND_NONE;
                // divide-by-zero ran its full latency but leaves HI/LO alone
                if (pend_kind == PEND_RESULT) begin
                    hi <= pend_hi;
                    lo <= pend_lo;
                end
            end else begin
                cnt <= cnt - 4'd1;
            end
        end else if (start) begin
            busy                <= 1'b1;
            cnt                 <= is_div(mdu_op) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            {pend_hi, pend_lo}  <= calc_res;
            pend_kind           <= calc_dz ? PEND_DIVZERO : PEND_RESULT;
        end else if (!req) begin
            if (op == MDU_MTHI) begin
                hi <= A;
            end else if (op == MDU_MTLO) begin
                lo <= A;
            end
        end
    end

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Self-checking bench for e_mdu_ctrl: directed scenarios plus randomized ops against a behavioural HI/LO model.
module tb_e_mdu_ctrl;
    import e_mdu_ctrl_pkg::*;

    localparam int unsigned NM = 5;
    localparam int unsigned ND = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic [3:0]  mdu_op = 4'd0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        start;
    logic        busy;
    logic [31:0] mdu_out;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    int total = 0;
    int bad   = 0;

    e_mdu_ctrl #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .mdu_op  (mdu_op),
        .A       (A),
        .B       (B),
        .start   (start),
        .busy    (busy),
        .mdu_out (mdu_out),
        .hi_q    (hi_q),
        .lo_q    (lo_q)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic r);
        mdu_op = op;
        A      = a;
        B      = b;
        req    = r;
        #1;
    endtask

    task automatic idle();
        drive(MDU_NONE, '0, '0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    // Architectural result: new {HI,LO} from the ISA rules using wide integer arithmetic
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] hi, input logic [31:0] lo);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        logic [63:0]     res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = 64'(a);
        ub  = 64'(b);
        res = {hi, lo};
        case (op)
            MDU_MULT:  res = 64'(sa * sb);
            MDU_MULTU: res = ua * ub;
            MDU_DIV: if (b != 0) begin
                q   = sa / sb;
                r   = sa % sb;
                res = {r[31:0], q[31:0]};
            end
            MDU_DIVU: if (b != 0) res = {32'(ua % ub), 32'(ua / ub)};
            MDU_MTHI: res[63:32] = a;
            MDU_MTLO: res[31:0]  = a;
            default: ;
        endcase
        return res;
    endfunction

    function automatic int unsigned lat(input logic [3:0] op);
        return is_div(op) ? ND : NM;
    endfunction

    task automatic test_reset();
        do_reset();
        total++;
        if ({busy, start, hi_q, lo_q} !== 66'b0) begin
            bad++;
            $display("FAIL reset_state got busy=%0b start=%0b hi=%08h lo=%08h want all 0", busy, start, hi_q, lo_q);
        end
        drive(MDU_MFHI, '0, '0, 1'b0);
        total++;
        if (mdu_out !== 32'h0) begin
            bad++;
            $display("FAIL reset_mfhi got %08h want 00000000", mdu_out);
        end
        idle();
    endtask

    task automatic test_arith(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                              input logic [31:0] old_hi, input logic [31:0] old_lo);
        int unsigned n;
        n = lat(op);
        drive(op, a, b, 1'b0);
        total++;
        if (start !== 1'b1) begin
            bad++;
            $display("FAIL %s_start got %0b want 1", name, start);
        end
        tick();
        for (int unsigned i = 0; i < n; i++) begin
            drive((i % 2 == 0) ? MDU_MFHI : MDU_MFLO, '0, '0, 1'b0);
            total++;
            if (busy !== 1'b1 || mdu_out !== ((i % 2 == 0) ? old_hi : old_lo)) begin
                bad++;
                $display("FAIL %s_busy cycle %0d got busy=%0b out=%08h want busy=1 out=%08h",
                         name, i + 1, busy, mdu_out, (i % 2 == 0) ? old_hi : old_lo);
            end
            tick();
        end
        idle();
        total++;
        if (busy !== 1'b0 || hi_q !== exp_hi || lo_q !== exp_lo) begin
            bad++;
            $display("FAIL %s_commit got busy=%0b hi=%08h lo=%08h want busy=0 hi=%08h lo=%08h",
                     name, busy, hi_q, lo_q, exp_hi, exp_lo);
        end
    endtask

    task automatic test_move();
        do_reset();
        drive(MDU_MTHI, 32'h1234_5678, '0, 1'b0);
        total++;
        if (start !== 1'b0) begin
            bad++;
            $display("FAIL mthi_start got %0b want 0", start);
        end
        tick();
        idle();
        total++;
        if (busy !== 1'b0 || hi_q !== 32'h1234_5678) begin
            bad++;
            $display("FAIL mthi_commit got busy=%0b hi=%08h want busy=0 hi=12345678", busy, hi_q);
        end
        drive(MDU_MFLO, '0, '0, 1'b0);
        total++;
        if (mdu_out !== 32'h0) begin
            bad++;
            $display("FAIL mflo_read got %08h want 00000000", mdu_out);
        end
        drive(MDU_MFHI, '0, '0, 1'b0);
        total++;
        if (mdu_out !== 32'h1234_5678) begin
            bad++;
            $display("FAIL mfhi_read got %08h want 12345678", mdu_out);
        end
        drive(MDU_MTHI, 32'd5, '0, 1'b0);
        tick();
        drive(MDU_MTLO, 32'd9, '0, 1'b0);
        tick();
        idle();
        total++;
        if (hi_q !== 32'd5 || lo_q !== 32'd9) begin
            bad++;
            $display("FAIL mt_pair got hi=%08h lo=%08h want hi=5 lo=9", hi_q, lo_q);
        end
    endtask

    task automatic test_req_suppress();
        drive(MDU_MULT, 32'd2, 32'd3, 1'b1);
        total++;
        if (start !== 1'b0) begin
            bad++;
            $display("FAIL req_start got %0b want 0", start);
        end
        tick();
        idle();
        total++;
        if (busy !== 1'b0 || hi_q !== 32'd5 || lo_q !== 32'd9) begin
            bad++;
            $display("FAIL req_mult got busy=%0b hi=%08h lo=%08h want busy=0 hi=5 lo=9", busy, hi_q, lo_q);
        end
        drive(MDU_MTLO, 32'hABC, '0, 1'b1);
        tick();
        drive(MDU_MTHI, 32'hDEF, '0, 1'b1);
        tick();
        idle();
        total++;
        if (hi_q !== 32'd5 || lo_q !== 32'd9) begin
            bad++;
            $display("FAIL req_mt got hi=%08h lo=%08h want hi=5 lo=9", hi_q, lo_q);
        end
    endtask

    task automatic test_req_inflight();
        drive(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        tick();
        idle();
        tick();
        tick();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL inflight_busy3 got %0b want 1", busy);
        end
        drive(MDU_NONE, '0, '0, 1'b1);
        tick();
        idle();
`ifdef MDU_ABORT_EN
        total++;
        if (busy !== 1'b0 || hi_q !== 32'd5 || lo_q !== 32'd9) begin
            bad++;
            $display("FAIL abort got busy=%0b hi=%08h lo=%08h want busy=0 hi=5 lo=9", busy, hi_q, lo_q);
        end
        tick();
        tick();
        tick();
        total++;
        if (busy !== 1'b0 || hi_q !== 32'd5 || lo_q !== 32'd9) begin
            bad++;
            $display("FAIL abort_hold got busy=%0b hi=%08h lo=%08h want busy=0 hi=5 lo=9", busy, hi_q, lo_q);
        end
`else
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL inflight_busy4 got %0b want 1", busy);
        end
        tick();
        total++;
        if (busy !== 1'b1 || hi_q !== 32'd5) begin
            bad++;
            $display("FAIL inflight_busy5 got busy=%0b hi=%08h want busy=1 hi=5", busy, hi_q);
        end
        tick();
        total++;
        if (busy !== 1'b0 || hi_q !== 32'hFFFF_FFFE || lo_q !== 32'h0000_0001) begin
            bad++;
            $display("FAIL inflight_commit got busy=%0b hi=%08h lo=%08h want busy=0 hi=fffffffe lo=00000001",
                     busy, hi_q, lo_q);
        end
`endif
    endtask

    task automatic test_reset_mid();
        drive(MDU_DIV, 32'd1000, 32'd3, 1'b0);
        tick();
        idle();
        tick();
        tick();
        tick();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_busy got %0b want 1", busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || hi_q !== 32'h0 || lo_q !== 32'h0) begin
            bad++;
            $display("FAIL rstmid_clear got busy=%0b hi=%08h lo=%08h want all 0", busy, hi_q, lo_q);
        end
        test_arith("mult_after_reset", MDU_MULT, 32'd7, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFDD, '0, '0);
    endtask

    task automatic test_random();
        logic [3:0]  ops [8];
        logic [3:0]  op;
        logic [31:0] a, b, rh, rl;
        logic [63:0] exp;
        logic        r;
        int unsigned cnt;
        ops = '{MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO, MDU_MFHI, MDU_MFLO};
        do_reset();
        rh = '0;
        rl = '0;
        for (int k = 0; k < 40; k++) begin
            op = ops[$urandom_range(0, 7)];
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 4))
                0:       b = '0;
                1:       b = 32'($urandom_range(1, 9));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            r   = ($urandom_range(0, 7) == 0);
            exp = r ? {rh, rl} : model(op, a, b, rh, rl);
            drive(op, a, b, r);
            if (op == MDU_MFHI || op == MDU_MFLO) begin
                total++;
                if (mdu_out !== ((op == MDU_MFHI) ? rh : rl)) begin
                    bad++;
                    $display("FAIL rnd_read %0d op=%0d got %08h want %08h", k, op, mdu_out,
                             (op == MDU_MFHI) ? rh : rl);
                end
                tick();
            end else if (is_muldiv(op)) begin
                total++;
                if (start !== !r) begin
                    bad++;
                    $display("FAIL rnd_start %0d op=%0d got %0b want %0b", k, op, start, !r);
                end
                tick();
                idle();
                cnt = 0;
                while (busy === 1'b1 && cnt < 20) begin
                    cnt++;
                    tick();
                end
                total++;
                if (cnt != (r ? 0 : lat(op)) || hi_q !== exp[63:32] || lo_q !== exp[31:0]) begin
                    bad++;
                    $display("FAIL rnd_op %0d op=%0d a=%08h b=%08h req=%0b got busy_cycles=%0d hi=%08h lo=%08h want busy_cycles=%0d hi=%08h lo=%08h",
                             k, op, a, b, r, cnt, hi_q, lo_q, r ? 0 : lat(op), exp[63:32], exp[31:0]);
                end
            end else begin
                tick();
                idle();
                total++;
                if (busy !== 1'b0 || hi_q !== exp[63:32] || lo_q !== exp[31:0]) begin
                    bad++;
                    $display("FAIL rnd_move %0d op=%0d req=%0b got busy=%0b hi=%08h lo=%08h want busy=0 hi=%08h lo=%08h",
                             k, op, r, busy, hi_q, lo_q, exp[63:32], exp[31:0]);
                end
            end
            rh = exp[63:32];
            rl = exp[31:0];
            idle();
        end
    endtask

    initial begin
        test_reset();
        test_arith("mult", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, '0, '0);
        test_arith("divu", MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        test_arith("div", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd2, 32'd14);
        test_arith("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000,
                   32'hFFFF_FFFF, 32'hFFFF_FFFD);
        test_move();
        test_arith("div_zero", MDU_DIV, 32'd123, 32'd0, 32'd5, 32'd9, 32'd5, 32'd9);
        test_req_suppress();
        test_req_inflight();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
